// File: rtl/fp_mul_writeback_queue.sv
// Retirement queue behind the FP multiplier: classifies and cleans MULF products,
// buffers them and drains them to the FP register-file write port.
module fp_mul_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int REG_AW = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [5:0]               in_opcode,
  input  logic [31:0]              in_result,
  input  logic [REG_AW-1:0]        in_dest,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [31:0]              wb_data,
  output logic [REG_AW-1:0]        wb_dest,
  output logic [3:0]               wb_flags,
  output logic [3:0]               sticky_flags,
  output logic                     drop_err,
  input  logic                     flags_clear,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [5:0] MULF = 6'b011000;

  logic [31:0]       dataMem_q  [DEPTH];
  logic [REG_AW-1:0] destMem_q  [DEPTH];
  logic [3:0]        flagsMem_q [DEPTH];

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    sticky_q, sticky_d;
  logic          drop_q, drop_d;

  logic        expAllOnes, expZero, fracZero;
  logic [31:0] cleanData;
  logic [3:0]  cleanFlags;
  logic        isMulf, enq, deq, dropEvent;

  assign expAllOnes = (in_result[30:23] == 8'hFF);
  assign expZero    = (in_result[30:23] == 8'h00);
  assign fracZero   = (in_result[22:0] == 23'd0);

  // Flag order is {denorm_flushed, nan, inf, zero}; a flushed denormal also reports zero.
  always_comb begin
    cleanData  = in_result;
    cleanFlags = 4'b0000;
    if (expAllOnes && fracZero) begin
      cleanFlags = 4'b0010;
    end else if (expAllOnes) begin
      cleanFlags = 4'b0100;
      cleanData  = 32'h7FC0_0000;
    end else if (expZero && !fracZero) begin
      cleanFlags = 4'b1001;
      cleanData  = {in_result[31], 31'd0};
    end else if (expZero) begin
      cleanFlags = 4'b0001;
    end
  end

  assign in_ready  = (count_q != CW'(DEPTH));
  assign wb_valid  = (count_q != '0);
  assign isMulf    = in_valid && (in_opcode == MULF);
  assign enq       = isMulf && in_ready;
  assign dropEvent = isMulf && !in_ready;
  assign deq       = wb_valid && wb_ready;

  assign wb_data  = wb_valid ? dataMem_q[rdPtr_q]  : 32'd0;
  assign wb_dest  = wb_valid ? destMem_q[rdPtr_q]  : '0;
  assign wb_flags = wb_valid ? flagsMem_q[rdPtr_q] : 4'd0;

  assign sticky_flags = sticky_q;
  assign drop_err     = drop_q;
  assign count        = count_q;

  always_comb begin
    wrPtr_d = enq ? wrPtr_q + PW'(1) : wrPtr_q;
    rdPtr_d = deq ? rdPtr_q + PW'(1) : rdPtr_q;
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A clear in the same cycle as a new event loses to the event's bits.
    sticky_d = (flags_clear ? 4'd0 : sticky_q) | (deq ? wb_flags : 4'd0);
    drop_d   = (flags_clear ? 1'b0 : drop_q) | dropEvent;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      sticky_q <= 4'd0;
      drop_q   <= 1'b0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
      drop_q   <= drop_d;
    end
  end

  // Storage is not reset; occupancy masks stale entries.
  always_ff @(posedge clk) begin
    if (enq) begin
      dataMem_q[wrPtr_q]  <= cleanData;
      destMem_q[wrPtr_q]  <= in_dest;
      flagsMem_q[wrPtr_q] <= cleanFlags;
    end
  end

endmodule

// File: doc/fp_mul_writeback_queue.md
# fp_mul_writeback_queue

Result-retirement stage directly downstream of the single-precision floating-point multiplier. It accepts each MULF product with its destination register and classifies it (zero, infinity, NaN, denormal). It cleans the value: NaN is canonicalised and denormals are flushed to zero. Results are then buffered in a small FIFO and drained to the floating-point register-file write port under a valid/ready handshake, while sticky exception flags are kept for software.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- REG_AW, 5: destination register address width.
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  multiplier result present this cycle.
- in_ready  out  1  queue can accept; equals (count != DEPTH).
- in_opcode  in  6  opcode accompanying the result; only MULF (6'b011000) is enqueued.
- in_result  in  32  IEEE-754 single product {sign, exp[7:0], frac[22:0]}.
- in_dest  in  REG_AW  destination register.
- wb_valid  out  1  head entry available; equals (count != 0).
- wb_ready  in  1  register-file write port accepts.
- wb_data  out  32  cleaned result of head entry; 0 when empty.
- wb_dest  out  REG_AW  destination of head entry; 0 when empty.
- wb_flags  out  4  head classification {denorm_flushed, nan, inf, zero}; 0 when empty.
- sticky_flags  out  4  OR of wb_flags of every retired entry since the last clear.
- drop_err  out  1  sticky: a MULF result was offered while full.
- flags_clear  in  1  synchronous clear of sticky_flags and drop_err.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Enqueue when in_valid && in_ready && in_opcode==MULF. Write {clean, dest, flags} at wr_ptr, and wr_ptr wraps modulo DEPTH.
- Non-MULF in_valid is ignored. It is neither enqueued nor flagged.
- MULF in_valid while full is dropped and sets drop_err. There is no backpressure beyond in_ready.
- Classification is computed from in_result before storage:
  - exp==8'hFF and frac==0: inf=1; data unchanged.
  - exp==8'hFF and frac!=0: nan=1; data = 32'h7FC00000.
  - exp==0 and frac!=0: denorm_flushed=1 and zero=1; data = {sign, 31'b0}.
  - exp==0 and frac==0: zero=1; data unchanged, sign kept.
  - Otherwise all flags are 0.
- Dequeue when wb_valid && wb_ready. rd_ptr wraps modulo DEPTH. sticky_flags |= wb_flags of the dequeued entry.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. When full, in_ready=0, so no same-cycle pass-through occurs even if wb_ready=1.
- flags_clear in the same cycle as a dequeue or drop: the new bits win (cleared, then the new event's bits are set).
- The head outputs are a combinational read of the entry at rd_ptr, masked to 0 when count==0.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert handled upstream) sets wr_ptr=rd_ptr=0, count=0, sticky_flags=0 and drop_err=0. Storage contents need not be cleared.
- Reset values of outputs: in_ready=1, wb_valid=0, wb_data=0, wb_dest=0, wb_flags=0, sticky_flags=0, drop_err=0, count=0.
- Reset mid-operation discards all queued entries. No write-back occurs after reset asserts.
- Latency: result enqueued at edge N appears on wb_* during cycle N+1 (one cycle), if it is at the head.
- Throughput is one result per cycle when wb_ready is held high.
- sticky_flags and drop_err update at the edge where the triggering event occurs.
- wb_* are stable while wb_valid && !wb_ready.

## Test plan
- Reset then idle: outputs read in_ready=1, wb_valid=0, count=0, and all data/flags 0.
- Enqueue 0x40000000 (dest 3) with wb_ready=1: the next cycle shows wb_valid=1, wb_data=0x40000000, wb_dest=3, wb_flags=0. After that, count returns to 0.
- Special-value sweep: inputs 0x7F800000, 0x7F812345, 0x80000001 and 0x00000000 each retire. Expected wb_flags: inf (4'b0010); nan (4'b0100) with data 0x7FC00000; 4'b1001 with data 0x80000000; zero (4'b0001). sticky_flags ends at 4'b1111.
- Fill with wb_ready=0: after DEPTH enqueues, count=DEPTH and in_ready=0. One more MULF sets drop_err=1, and count is unchanged. Draining yields the entries in original order, with pointers wrapping correctly.
- Non-MULF opcode with in_valid=1: count and sticky_flags are unchanged.
- flags_clear pulsed together with a dequeue of a NaN entry: sticky_flags=4'b0100 afterwards. Assert reset_n low with 3 entries queued: count=0 and wb_valid=0 immediately, without waiting for a clock edge.
